// File: rtl/rr_mux_reg.sv
// rr_mux_reg: N-input registered multiplexer with valid/ready handshakes.
// The channel is chosen internally, either round-robin (starting at rr_ptr)
// or fixed priority (lowest index wins). A single output register stage
// gives a latency of one cycle and a throughput of one beat per cycle.
module rr_mux_reg #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    localparam int SELW = (N > 1) ? $clog2(N) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               prio_mode,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_sel,
    output logic               out_valid,
    input  logic               out_ready
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t            state_r;
    logic [WIDTH-1:0]  out_data_r;
    logic [SELW-1:0]   out_sel_r;
    logic [SELW-1:0]   rr_ptr_r;

    logic              load_en_s;
    logic              any_valid_s;
    logic [SELW-1:0]   grant_idx_s;
    logic [N-1:0]      grant_s;
    logic [WIDTH-1:0]  sel_data_s;
    logic [SELW-1:0]   next_ptr_s;

    // The output register can take a new beat when empty or when its beat leaves now.
    assign load_en_s = (state_r == ST_EMPTY) || out_ready;

    // Arbitration: pick the valid channel with the smallest search distance.
    // Distance is the channel index in fixed mode, or the wrapped offset from rr_ptr in RR mode.
    always_comb begin
        int ptr;
        int key;
        int best_key;
        ptr         = int'(rr_ptr_r);
        key         = 0;
        best_key    = N;
        any_valid_s = 1'b0;
        grant_idx_s = {SELW{1'b0}};
        for (int j = 0; j < N; j++) begin
            if (prio_mode) begin
                key = j;
            end else if (j >= ptr) begin
                key = j - ptr;
            end else begin
                key = j + N - ptr;
            end
            if (in_valid[j] && (key < best_key)) begin
                best_key    = key;
                grant_idx_s = SELW'(j);
                any_valid_s = 1'b1;
            end else begin
                best_key    = best_key;
            end
        end
    end

    // Expand the winning index into a one-hot grant and select its data (AND-OR mux).
    always_comb begin
        grant_s    = {N{1'b0}};
        sel_data_s = {WIDTH{1'b0}};
        for (int j = 0; j < N; j++) begin
            grant_s[j] = any_valid_s && (grant_idx_s == SELW'(j));
            sel_data_s = sel_data_s | ({WIDTH{grant_s[j]}} & in_data[j*WIDTH +: WIDTH]);
        end
    end

    // Round-robin pointer moves to the channel after the one just granted, wrapping at N-1.
    always_comb begin
        if (grant_idx_s == SELW'(N - 1)) begin
            next_ptr_s = {SELW{1'b0}};
        end else begin
            next_ptr_s = grant_idx_s + SELW'(1);
        end
    end

    assign in_ready = {N{load_en_s}} & grant_s;

    // Output stage FSM: EMPTY/FULL tracks out_valid; loads the granted beat whenever load is allowed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_EMPTY;
            out_data_r <= {WIDTH{1'b0}};
            out_sel_r  <= {SELW{1'b0}};
            rr_ptr_r   <= {SELW{1'b0}};
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (any_valid_s) begin
                        state_r    <= ST_FULL;
                        out_data_r <= sel_data_s;
                        out_sel_r  <= grant_idx_s;
                        rr_ptr_r   <= next_ptr_s;
                    end else begin
                        state_r    <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_ready && any_valid_s) begin
                        state_r    <= ST_FULL;
                        out_data_r <= sel_data_s;
                        out_sel_r  <= grant_idx_s;
                        rr_ptr_r   <= next_ptr_s;
                    end else if (out_ready) begin
                        state_r    <= ST_EMPTY;
                    end else begin
                        state_r    <= ST_FULL;
                    end
                end
                default: begin
                    state_r <= ST_EMPTY;
                end
            endcase
        end
    end

    assign out_valid = (state_r == ST_FULL);
    assign out_data  = out_data_r;
    assign out_sel   = out_sel_r;

endmodule

// File: tb/tb_rr_mux_reg.sv
// Directed testbench for rr_mux_reg (N=4, WIDTH=32) with hand-computed expectations.
module tb_rr_mux_reg;

    localparam int WIDTH = 32;
    localparam int N     = 4;
    localparam int SELW  = 2;

    logic               clk;
    logic               rst_n;
    logic               prio_mode;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [WIDTH-1:0]   out_data;
    logic [SELW-1:0]    out_sel;
    logic               out_valid;
    logic               out_ready;

    int checks = 0;
    int errors = 0;

    rr_mux_reg #(.WIDTH(WIDTH), .N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .prio_mode (prio_mode),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; prio_mode = 1'b0; in_valid = 4'b0000; out_ready = 1'b0;
        for (int i = 0; i < N; i++) in_data[i*WIDTH +: WIDTH] = 32'hA0 + 32'(i);
        step(); step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", out_data); end
        checks++; if (out_sel !== 2'd0) begin errors++; $display("FAIL reset_sel got=%0d exp=0", out_sel); end
        checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got=%b exp=0000", in_ready); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_rr_rotation();
        logic [1:0]  exp_sel [5];
        logic [3:0]  exp_rdy [5];
        exp_sel = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        exp_rdy = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        prio_mode = 1'b0; out_ready = 1'b1; in_valid = 4'b1111;
        #1;
        checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL rr_first_ready got=%b exp=0001", in_ready); end
        for (int j = 0; j < 5; j++) begin
            step();
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rr_valid[%0d] got=%b exp=1", j, out_valid); end
            checks++; if (out_sel !== exp_sel[j]) begin errors++; $display("FAIL rr_sel[%0d] got=%0d exp=%0d", j, out_sel, exp_sel[j]); end
            checks++; if (out_data !== 32'hA0 + 32'(exp_sel[j])) begin errors++; $display("FAIL rr_data[%0d] got=%h exp=%h", j, out_data, 32'hA0 + 32'(exp_sel[j])); end
            checks++; if (in_ready !== exp_rdy[j]) begin errors++; $display("FAIL rr_ready[%0d] got=%b exp=%b", j, in_ready, exp_rdy[j]); end
        end
        in_valid = 4'b0000;   // rr_ptr is now 1
    endtask

    task automatic test_fixed_prio();
        prio_mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL fix_ready_now got=%b exp=0001", in_ready); end
        for (int j = 0; j < 3; j++) begin
            step();
            checks++; if (out_sel !== 2'd0) begin errors++; $display("FAIL fix_sel[%0d] got=%0d exp=0", j, out_sel); end
            checks++; if (out_data !== 32'hA0) begin errors++; $display("FAIL fix_data[%0d] got=%h exp=a0", j, out_data); end
            checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL fix_ready[%0d] got=%b exp=0001", j, in_ready); end
        end
        in_valid = 4'b0000;   // rr_ptr is now 1
        prio_mode = 1'b0;
    endtask

    task automatic test_backpressure();
        prio_mode = 1'b0; in_valid = 4'b1111; out_ready = 1'b1;
        step();               // channel 1 loaded, rr_ptr -> 2
        out_ready = 1'b0;
        #1;
        checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready_now got=%b exp=0000", in_ready); end
        for (int j = 0; j < 3; j++) begin
            step();
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got=%b exp=1", j, out_valid); end
            checks++; if (out_data !== 32'hA1) begin errors++; $display("FAIL bp_data[%0d] got=%h exp=a1", j, out_data); end
            checks++; if (out_sel !== 2'd1) begin errors++; $display("FAIL bp_sel[%0d] got=%0d exp=1", j, out_sel); end
            checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready[%0d] got=%b exp=0000", j, in_ready); end
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 4'b0100) begin errors++; $display("FAIL bp_release_ready got=%b exp=0100", in_ready); end
        step();               // channel 2 loaded, rr_ptr -> 3
        checks++; if (out_data !== 32'hA2) begin errors++; $display("FAIL bp_release_data got=%h exp=a2", out_data); end
        checks++; if (out_sel !== 2'd2) begin errors++; $display("FAIL bp_release_sel got=%0d exp=2", out_sel); end
        in_valid = 4'b0000;
    endtask

    task automatic test_rr_wrap();
        in_valid = 4'b0100;   // rr_ptr is 3
        #1;
        checks++; if (in_ready !== 4'b0100) begin errors++; $display("FAIL wrap_ready got=%b exp=0100", in_ready); end
        step();               // channel 2 loaded, rr_ptr -> 3
        checks++; if (out_sel !== 2'd2) begin errors++; $display("FAIL wrap_sel got=%0d exp=2", out_sel); end
        checks++; if (out_data !== 32'hA2) begin errors++; $display("FAIL wrap_data got=%h exp=a2", out_data); end
        in_valid = 4'b1111;
        #1;
        checks++; if (in_ready !== 4'b1000) begin errors++; $display("FAIL wrap_ptr_ready got=%b exp=1000", in_ready); end
        in_valid = 4'b0000;
    endtask

    task automatic test_idle();
        in_valid = 4'b0000; out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL idle_ready got=%b exp=0000", in_ready); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 32'hA2) begin errors++; $display("FAIL idle_data got=%h exp=a2", out_data); end
        checks++; if (out_sel !== 2'd2) begin errors++; $display("FAIL idle_sel got=%0d exp=2", out_sel); end
    endtask

    task automatic test_async_reset();
        in_valid = 4'b0001; out_ready = 1'b1; prio_mode = 1'b0;
        step();               // channel 0 loaded (wrap from rr_ptr 3), rr_ptr -> 1
        in_valid = 4'b0000; out_ready = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b1 || out_data !== 32'hA0) begin errors++; $display("FAIL ar_pre got=%b/%h exp=1/a0", out_valid, out_data); end
        #1;
        rst_n = 1'b0;
        #1;                   // still before the next rising edge
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ar_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL ar_data got=%h exp=0", out_data); end
        checks++; if (out_sel !== 2'd0) begin errors++; $display("FAIL ar_sel got=%0d exp=0", out_sel); end
        step();
        rst_n = 1'b1;
        in_valid = 4'b1111; out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL ar_ptr_ready got=%b exp=0001", in_ready); end
        in_valid = 4'b0000;
    endtask

    initial begin
        test_reset();
        test_rr_rotation();
        test_fixed_prio();
        test_backpressure();
        test_rr_wrap();
        test_idle();
        test_async_reset();
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
